// File: rtl/mem_bus_adapter.sv
// mem_bus_adapter: bridges a level-held CPU memory port to a req/gnt + rvalid bus with optional timeout
module mem_bus_adapter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err,
  output logic        pmem_req,
  output logic        pmem_we,
  output logic [31:0] pmem_addr,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_be,
  input  logic        pmem_gnt,
  input  logic        pmem_rvalid,
  input  logic [31:0] pmem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, nxt;
  logic start, busy, to;
  assign start = (state == IDLE) && (mem_read || mem_write);
  assign busy = (state == REQ) || (state == WAIT);
`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic err;
  assign to = busy && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign mem_err = err && (state == RESP);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else cnt <= busy ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (start) err <= 1'b0;
    else if (to) err <= 1'b1;
  end
`else
  assign to = 1'b0;
  assign mem_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == IDLE ? (start ? REQ : IDLE) :
          state == REQ  ? (to ? RESP : (pmem_gnt ? WAIT : REQ)) :
          state == WAIT ? ((to || pmem_rvalid) ? RESP : WAIT) : IDLE;
    pmem_req = state == REQ;
    mem_resp = state == RESP;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pmem_we <= 1'b0;
      pmem_addr <= '0;
      pmem_wdata <= '0;
      pmem_be <= '0;
    end else if (start) begin
      pmem_we <= mem_write;
      pmem_addr <= {mem_address[31:2], 2'b00};
      pmem_wdata <= mem_wdata;
      pmem_be <= mem_write ? mem_byte_enable : 4'b1111;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_rdata <= '0;
    else if (to) mem_rdata <= 32'hDEADBEEF;
    else if ((state == WAIT) && pmem_rvalid && !pmem_we) mem_rdata <= pmem_rdata;
  end
endmodule

// File: tb/tb_mem_bus_adapter.sv
// tb_mem_bus_adapter: scoreboard bench for mem_bus_adapter (build with MEM_BUS_TIMEOUT_EN for the timeout scenario)
module tb_mem_bus_adapter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] mem_address = '0, mem_wdata = '0;
  logic [3:0]  mem_byte_enable = '0;
  logic [31:0] mem_rdata;
  logic        mem_resp, mem_err;
  logic        pmem_req, pmem_we;
  logic [31:0] pmem_addr, pmem_wdata;
  logic [3:0]  pmem_be;
  logic        pmem_gnt = 1'b0, pmem_rvalid = 1'b0;
  logic [31:0] pmem_rdata = '0;
  int          vectors = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  logic [31:0] last_rd = '0;

  mem_bus_adapter #(.TIMEOUT_CYCLES(16)) dut (.*);

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_err && !mem_resp) begin
      vectors++;
      errors++;
      $display("FAIL err_without_resp: mem_err=1 while mem_resp=0");
    end
    if (mem_resp) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got rdata=%h err=%b, none expected", mem_rdata, mem_err);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_rdata, mem_err} !== mon_e) begin
          errors++;
          $display("FAIL resp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                   mem_rdata, mem_err, mon_e[32:1], mon_e[0]);
        end
      end
    end
  end

  task automatic bus_access(input logic we, input logic rd, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input int gnt_dly, input int rv_dly, input logic [31:0] bus_rd);
    int req_cycles = 0;
    logic [3:0] exp_be = we ? be : 4'b1111;
    mem_write = we;
    mem_read = rd;
    mem_address = addr;
    mem_wdata = wdata;
    mem_byte_enable = be;
    exp_q.push_back(we ? {last_rd, 1'b0} : {bus_rd, 1'b0});
    if (!we) last_rd = bus_rd;
    @(negedge clk);
    mem_address = ~addr;
    mem_wdata = ~wdata;
    mem_byte_enable = ~be;
    for (int k = 0; k < gnt_dly; k++) begin
      req_cycles += int'(pmem_req);
      @(negedge clk);
    end
    req_cycles += int'(pmem_req);
    vectors++;
    if ({pmem_req, pmem_we, pmem_addr, pmem_be} !== {1'b1, we, addr[31:2], 2'b00, exp_be}) begin
      errors++;
      $display("FAIL bus_fields: got req=%b we=%b addr=%h be=%b, expected req=1 we=%b addr=%h be=%b",
               pmem_req, pmem_we, pmem_addr, pmem_be, we, {addr[31:2], 2'b00}, exp_be);
    end
    if (we) begin
      vectors++;
      if (pmem_wdata !== wdata) begin
        errors++;
        $display("FAIL bus_wdata: got %h, expected %h", pmem_wdata, wdata);
      end
    end
    pmem_gnt = 1'b1;
    @(negedge clk);
    pmem_gnt = 1'b0;
    vectors++;
    if (req_cycles !== gnt_dly + 1 || pmem_req !== 1'b0) begin
      errors++;
      $display("FAIL req_hold: got %0d req cycles, req after gnt=%b, expected %0d cycles and 0",
               req_cycles, pmem_req, gnt_dly + 1);
    end
    repeat (rv_dly) @(negedge clk);
    pmem_rvalid = 1'b1;
    pmem_rdata = bus_rd;
    @(negedge clk);
    pmem_rvalid = 1'b0;
    pmem_rdata = $urandom;
    vectors++;
    if (mem_resp !== 1'b1) begin
      errors++;
      $display("FAIL resp_latency: got mem_resp=%b one cycle after rvalid, expected 1", mem_resp);
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_resp !== 1'b0 || pmem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_resp: got resp=%b req=%b, expected 0 0", mem_resp, pmem_req);
    end
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if ({mem_resp, mem_err, pmem_req, pmem_we, pmem_addr, pmem_wdata, pmem_be, mem_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got resp=%b req=%b addr=%h be=%b rdata=%h, expected all 0",
               mem_resp, pmem_req, pmem_addr, pmem_be, mem_rdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_resp, pmem_req, mem_rdata} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got resp=%b req=%b rdata=%h, expected 0", mem_resp, pmem_req, mem_rdata);
    end
  endtask

  task automatic test_read;
    bus_access(1'b0, 1'b1, 32'h0000_1006, 32'h0, 4'b0000, 0, 0, 32'hA5A5_1234);
  endtask

  task automatic test_write;
    bus_access(1'b1, 1'b0, 32'h0000_2000, 32'h0000_BEEF, 4'b0011, 4, 2, 32'h0BAD_0BAD);
  endtask

  task automatic test_back_to_back;
    bus_access(1'b0, 1'b1, 32'h0000_3008, 32'h0, 4'b0000, 1, 0, 32'h1111_2222);
    bus_access(1'b1, 1'b1, 32'h0000_300F, 32'hCAFE_F00D, 4'b1100, 0, 1, 32'h3333_4444);
    bus_access(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 4'b0101, 2, 3, 32'h5A5A_C3C3);
  endtask

  task automatic test_stray_rvalid;
    pmem_rvalid = 1'b1;
    pmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    pmem_rvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_resp !== 1'b0 || mem_rdata !== last_rd) begin
      errors++;
      $display("FAIL stray_idle: got resp=%b rdata=%h, expected 0 %h", mem_resp, mem_rdata, last_rd);
    end
    mem_read = 1'b1;
    mem_address = 32'h0000_0040;
    exp_q.push_back({32'h7777_8888, 1'b0});
    @(negedge clk);
    pmem_rvalid = 1'b1;
    pmem_rdata = 32'h9999_0000;
    @(negedge clk);
    pmem_rvalid = 1'b0;
    vectors++;
    if (pmem_req !== 1'b1 || mem_resp !== 1'b0 || mem_rdata !== last_rd) begin
      errors++;
      $display("FAIL stray_req: got req=%b resp=%b rdata=%h, expected 1 0 %h",
               pmem_req, mem_resp, mem_rdata, last_rd);
    end
    pmem_gnt = 1'b1;
    @(negedge clk);
    pmem_gnt = 1'b0;
    pmem_rvalid = 1'b1;
    pmem_rdata = 32'h7777_8888;
    @(negedge clk);
    pmem_rvalid = 1'b0;
    last_rd = 32'h7777_8888;
    vectors++;
    if (mem_resp !== 1'b1) begin
      errors++;
      $display("FAIL stray_then_real: got mem_resp=%b, expected 1", mem_resp);
    end
    mem_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait;
    mem_read = 1'b1;
    mem_address = 32'h0000_0080;
    @(negedge clk);
    pmem_gnt = 1'b1;
    @(negedge clk);
    pmem_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({mem_resp, mem_err, pmem_req, pmem_we, pmem_addr, pmem_wdata, pmem_be, mem_rdata} !== '0) begin
      errors++;
      $display("FAIL async_reset: got resp=%b req=%b addr=%h be=%b rdata=%h, expected all 0",
               mem_resp, pmem_req, pmem_addr, pmem_be, mem_rdata);
    end
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    pmem_rvalid = 1'b1;
    pmem_rdata = 32'h1234_5678;
    @(negedge clk);
    pmem_rvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_resp !== 1'b0 || pmem_req !== 1'b0 || mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rvalid_after_reset: got resp=%b req=%b rdata=%h, expected 0 0 0",
               mem_resp, pmem_req, mem_rdata);
    end
  endtask

  task automatic test_timeout;
    int n = 0;
    mem_read = 1'b1;
    mem_address = 32'h0000_0100;
`ifdef MEM_BUS_TIMEOUT_EN
    exp_q.push_back({32'hDEAD_BEEF, 1'b1});
    @(negedge clk);
    while (!mem_resp && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n !== 16 || pmem_req !== 1'b0 || mem_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout: got resp after %0d cycles req=%b err=%b, expected 16 0 1", n, pmem_req, mem_err);
    end
    mem_read = 1'b0;
    last_rd = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_access(1'b0, 1'b1, 32'h0000_0200, 32'h0, 4'b0000, 0, 0, 32'h0F0F_F0F0);
`else
    @(negedge clk);
    repeat (1000) begin
      n += int'(mem_resp);
      @(negedge clk);
    end
    vectors++;
    if (n !== 0 || pmem_req !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout: got %0d resps req=%b after 1000 cycles, expected 0 1", n, pmem_req);
    end
    mem_read = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_back_to_back;
    test_stray_rvalid;
    test_reset_in_wait;
    test_timeout;
    repeat (2) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_resp: got %0d outstanding expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
